ps2_host_transmitter: RTL
=========================

Name: ps2_host_transmitter

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- It sits beside the PS/2 receiver on the 25 MHz domain and drives the PS2_CLK/PS2_DATA pads open-drain through top-level tristate buffers.
- Busy_Out tells the receiver to ignore bus activity while this block owns the bus.

Parameters:
- INHIBIT_CYCLES, 3000, clock-low inhibit time before the request (120 us at 25 MHz).
- REQ_CYCLES, 25, data-low hold with clock still low before clock release (1 us).
- START_TIMEOUT_CYCLES, 375000, maximum wait from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 50000, maximum time from the first falling edge to the ack edge (2 ms).
- FILTER_LEN, 8, consecutive equal samples required to change a filtered line value.
- MAX_RETRIES, 2, retry count; used only with PS2_TX_RETRY_EN.

Ports:
- Master_Clock_In  in  1  25 MHz system clock.
- Reset_In  in  1  synchronous reset, active-high.
- Tx_Data_In  in  8  command byte.
- Tx_Valid_In  in  1  request; the byte is accepted when Tx_Valid_In and Tx_Ready_Out are both high.
- Tx_Ready_Out  out  1  high only in IDLE.
- PS2_Clk_In  in  1  raw PS2_CLK pad value.
- PS2_Data_In  in  1  raw PS2_DATA pad value.
- PS2_Clk_Drive_Out  out  1  1 = pull PS2_CLK low, 0 = release.
- PS2_Data_Drive_Out  out  1  1 = pull PS2_DATA low, 0 = release.
- Busy_Out  out  1  high in every state except IDLE.
- Tx_Done_Out  out  1  one-cycle pulse on successful, acknowledged transfer.
- Tx_Ack_Err_Out  out  1  one-cycle pulse when the device did not ack.
- Tx_Timeout_Out  out  1  one-cycle pulse on start or transfer timeout.

Behaviour:
- Reset values, all taking effect on the cycle after Reset_In is sampled high: Tx_Ready_Out=1; all other outputs 0; state IDLE; counters and shift register cleared.
- Reset mid-transfer releases both lines on that same next cycle. No status pulse is issued.
- Input conditioning:
  - each pad input passes a 2-flop synchroniser, then a FILTER_LEN glitch filter;
  - a falling edge is filtered clock 1->0;
  - edge detection latency from the pad is 2+FILTER_LEN cycles.
- On accept: latch the byte and compute odd parity, p = ~^Tx_Data_In. Tx_Valid_In is ignored while busy.
- IDLE: both drives 0. On accept go to INHIBIT.
- INHIBIT: Clk_Drive=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: Clk_Drive=1 and Data_Drive=1 for REQ_CYCLES, then go to WAIT_CLK.
- WAIT_CLK:
  - Clk_Drive=0; Data_Drive stays 1, which is the start bit;
  - on the first falling edge go to SEND with bit index 0 and drive data bit 0;
  - if START_TIMEOUT_CYCLES elapse first, go to ERR with timeout.
- SEND:
  - each subsequent falling edge presents the next value: data bits 1..7 LSB first, then parity, then stop;
  - Data_Drive = ~bit, so a 1 is sent by releasing the line;
  - the stop bit releases data (Data_Drive=0), then go to ACK.
- ACK: on the next falling edge (edge 11 counted from the start of WAIT_CLK), sample filtered data.
  - 0 -> go to WAIT_IDLE.
  - 1 -> go to ERR with ack error.
- WAIT_IDLE: wait until filtered clock and data are both 1, then pulse Tx_Done_Out and go to IDLE.
- XFER_TIMEOUT_CYCLES runs from the first falling edge until the ACK sample. On expiry in SEND or ACK, go to ERR with timeout.
- ERR: lasts 1 cycle. Both drives are 0 in ERR. Pulse the matching error output and go to IDLE.
- Tx_Ready_Out rises in the cycle after any Done or Err pulse.
- Exactly one of Done, Ack_Err or Timeout pulses per accepted byte.
- Counters saturate and never wrap. A device falling edge in IDLE, INHIBIT or REQ is ignored.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - an ack error or timeout restarts from INHIBIT with the same byte;
  - this repeats up to MAX_RETRIES times, with Busy_Out held high throughout;
  - the error pulse is issued only after the final failed attempt;
  - the retry count clears on accept.
- Undefined: the first failure pulses the error output immediately. MAX_RETRIES is unused.

Test Plan:
- Send 0xED to a device model that acks -> data sequence start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ack seen; Tx_Done_Out one pulse; Busy_Out low afterwards.
- Send 0x01 -> parity bit 0. Clk_Drive_Out is high exactly 3025 cycles after accept: 3000 inhibit + 25 request.
- Device model holds data high at edge 11 -> Tx_Ack_Err_Out one pulse; both drives 0; Tx_Ready_Out=1 next cycle.
- No device clock -> Tx_Timeout_Out pulses 375000 cycles after clock release.
- Device stops clocking after bit 3 -> Tx_Timeout_Out pulses at the 2 ms limit.
- Reset_In high after data bit 4 -> next cycle both drives 0, Ready=1, no status pulse. A subsequent send of 0xF4 succeeds.
- With PS2_TX_RETRY_EN, device never acks -> 3 full frames on the bus, then a single Tx_Ack_Err_Out pulse.

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: sends one byte with odd parity
// over the open-drain PS2_CLK/PS2_DATA pair and reports done/ack/timeout.
// Ports: Master_Clock_In/Reset_In (sync, active-high); Tx_Data_In,
//   Tx_Valid_In, Tx_Ready_Out byte handshake; PS2_Clk_In/PS2_Data_In raw
//   pads; PS2_*_Drive_Out pull-low enables; Busy_Out bus ownership;
//   Tx_Done_Out, Tx_Ack_Err_Out, Tx_Timeout_Out one-cycle status pulses.
// Build option: define PS2_TX_RETRY_EN to retry failed frames up to
//   MAX_RETRIES times before reporting the error.
module ps2_host_transmitter #(
   parameter int INHIBIT_CYCLES       = 3000,
   parameter int REQ_CYCLES           = 25,
   parameter int START_TIMEOUT_CYCLES = 375000,
   parameter int XFER_TIMEOUT_CYCLES  = 50000,
   parameter int FILTER_LEN           = 8,
   parameter int MAX_RETRIES          = 2
) (
   input  logic       Master_Clock_In,
   input  logic       Reset_In,
   input  logic [7:0] Tx_Data_In,
   input  logic       Tx_Valid_In,
   output logic       Tx_Ready_Out,
   input  logic       PS2_Clk_In,
   input  logic       PS2_Data_In,
   output logic       PS2_Clk_Drive_Out,
   output logic       PS2_Data_Drive_Out,
   output logic       Busy_Out,
   output logic       Tx_Done_Out,
   output logic       Tx_Ack_Err_Out,
   output logic       Tx_Timeout_Out
);

   localparam int MAX_AB = (INHIBIT_CYCLES > REQ_CYCLES) ?
                           INHIBIT_CYCLES : REQ_CYCLES;
   localparam int MAX_CD = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                           START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
   localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAX_C + 1);
   localparam int FW     = $clog2(FILTER_LEN + 1);
   localparam int RW     = $clog2(MAX_RETRIES + 2);
`ifdef PS2_TX_RETRY_EN
   localparam int RETRY_LIM = MAX_RETRIES;
`else
   localparam int RETRY_LIM = 0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_WAIT_CLK,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE,
      S_ERR
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   timer;
   logic [CW-1:0]   xfer;
   logic [3:0]      bit_idx;
   logic [8:0]      frame;
   logic [8:0]      shreg;
   logic            err_to;
   logic [RW-1:0]   retry_cnt;
   logic            accept;
   logic            fail_to, fail_ack;
   logic            retry_ok;

   // Pad conditioning: [0] = clock, [1] = data
   logic [1:0]      pad, s1, s2, filt;
   logic [FW-1:0]   fcnt [2];
   logic            clk_prev;
   logic            clk_fall;

   assign pad = {PS2_Data_In, PS2_Clk_In};

   // A filtered line only follows the synchronised pad after
   // FILTER_LEN consecutive samples that disagree with it.
   always_ff @(posedge Master_Clock_In) begin
      if (Reset_In) begin
         s1       <= 2'b11;
         s2       <= 2'b11;
         filt     <= 2'b11;
         fcnt[0]  <= '0;
         fcnt[1]  <= '0;
         clk_prev <= 1'b1;
      end else begin
         s1       <= pad;
         s2       <= s1;
         clk_prev <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
               fcnt[i] <= '0;
               filt[i] <= s2[i];
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign clk_fall = clk_prev & ~filt[0];
   assign accept   = Tx_Valid_In & Tx_Ready_Out;
   assign retry_ok = (retry_cnt != RW'(RETRY_LIM));

   always_comb begin
      state_nxt = state;
      fail_to   = 1'b0;
      fail_ack  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_INHIBIT;
         end
         S_INHIBIT: begin
            if (timer == CW'(INHIBIT_CYCLES - 1)) state_nxt = S_REQ;
         end
         S_REQ: begin
            if (timer == CW'(REQ_CYCLES - 1)) state_nxt = S_WAIT_CLK;
         end
         S_WAIT_CLK: begin
            if (clk_fall) state_nxt = S_SEND;
            else if (timer >= CW'(START_TIMEOUT_CYCLES - 1)) fail_to = 1'b1;
         end
         S_SEND: begin
            if (xfer >= CW'(XFER_TIMEOUT_CYCLES - 1)) fail_to = 1'b1;
            else if (clk_fall && bit_idx == 4'd8) state_nxt = S_ACK;
         end
         S_ACK: begin
            if (xfer >= CW'(XFER_TIMEOUT_CYCLES - 1)) fail_to = 1'b1;
            else if (clk_fall) begin
               if (filt[1]) fail_ack = 1'b1;
               else         state_nxt = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (filt[0] && filt[1]) state_nxt = S_IDLE;
         end
         S_ERR: begin
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (fail_to || fail_ack) state_nxt = retry_ok ? S_INHIBIT : S_ERR;
   end

   always_ff @(posedge Master_Clock_In) begin
      if (Reset_In) begin
         state     <= S_IDLE;
         timer     <= '0;
         xfer      <= '0;
         bit_idx   <= '0;
         frame     <= '0;
         shreg     <= '0;
         err_to    <= 1'b0;
         retry_cnt <= '0;
      end else begin
         state <= state_nxt;

         // Per-state timer restarts on every state change
         if (state_nxt != state)   timer <= '0;
         else if (timer != '1)     timer <= timer + 1'b1;

         if (accept) begin
            frame     <= {~^Tx_Data_In, Tx_Data_In};
            retry_cnt <= '0;
         end else if ((fail_to || fail_ack) && retry_ok) begin
            retry_cnt <= retry_cnt + 1'b1;
         end

         // First device edge: load the frame, start the transfer timer
         if (state == S_WAIT_CLK && state_nxt == S_SEND) begin
            shreg   <= frame;
            bit_idx <= '0;
            xfer    <= '0;
         end else begin
            if (state == S_SEND && clk_fall) begin
               shreg   <= {1'b0, shreg[8:1]};
               bit_idx <= bit_idx + 1'b1;
            end
            if ((state == S_SEND || state == S_ACK) && xfer != '1)
               xfer <= xfer + 1'b1;
         end

         if (state_nxt == S_ERR) err_to <= fail_to;
      end
   end

   assign Tx_Ready_Out       = (state == S_IDLE);
   assign Busy_Out           = (state != S_IDLE);
   assign PS2_Clk_Drive_Out  = (state == S_INHIBIT) || (state == S_REQ);
   // Start bit is the data pull held from REQ through WAIT_CLK
   assign PS2_Data_Drive_Out = (state == S_REQ) || (state == S_WAIT_CLK) ||
                               ((state == S_SEND) && !shreg[0]);
   assign Tx_Done_Out        = (state == S_WAIT_IDLE) && filt[0] && filt[1];
   assign Tx_Ack_Err_Out     = (state == S_ERR) && !err_to;
   assign Tx_Timeout_Out     = (state == S_ERR) && err_to;

endmodule
